wb_gpio_irq: RTL and testbench

//  Wishbone B4 classic slave GPIO bank: drives board LEDs/IO headers and samples keys.

---
 rtl/wb_gpio_irq.sv | 154 +++++++++++++++
 tb/tb_wb_gpio_irq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_irq.sv
// Wishbone B4 classic GPIO bank: per-pin direction, 2-FF synchronised and
// prescaler-debounced inputs, per-pin rising/falling edge capture with level IRQ.
module wb_gpio_irq #(
   parameter int                    GPIO_WIDTH    = 8,
   parameter int                    DEBOUNCE_BITS = 16,
   parameter logic [GPIO_WIDTH-1:0] OUT_RESET     = {GPIO_WIDTH{1'b0}}
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic [2:0]            wb_adr_i,
   input  logic [31:0]           wb_dat_i,
   input  logic [3:0]            wb_sel_i,
   input  logic                  wb_we_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   output logic [31:0]           wb_dat_o,
   output logic                  wb_ack_o,
   input  logic [GPIO_WIDTH-1:0] gpio_i,
   output logic [GPIO_WIDTH-1:0] gpio_o,
   output logic [GPIO_WIDTH-1:0] gpio_oe_o,
   output logic                  irq_o
);

   localparam logic [2:0] ADR_DATA_OUT   = 3'd0;
   localparam logic [2:0] ADR_DIR        = 3'd1;
   localparam logic [2:0] ADR_DATA_IN    = 3'd2;
   localparam logic [2:0] ADR_IRQ_EN     = 3'd3;
   localparam logic [2:0] ADR_IRQ_STATUS = 3'd4;
   localparam logic [2:0] ADR_EDGE       = 3'd5;
   localparam logic [2:0] ADR_DB_DIV     = 3'd6;
   localparam logic [2:0] ADR_RAW_IN     = 3'd7;

   localparam logic [GPIO_WIDTH-1:0]    G_ZERO   = {GPIO_WIDTH{1'b0}};
   localparam logic [DEBOUNCE_BITS-1:0] D_ZERO   = {DEBOUNCE_BITS{1'b0}};
   localparam logic [DEBOUNCE_BITS-1:0] PRESC_ONE = DEBOUNCE_BITS'(1);

   function automatic logic [31:0] byte_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

   function automatic logic [GPIO_WIDTH-1:0] merge_g(input logic [GPIO_WIDTH-1:0] old_v,
                                                    input logic [GPIO_WIDTH-1:0] new_v,
                                                    input logic [GPIO_WIDTH-1:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   logic [GPIO_WIDTH-1:0]    data_out_r, dir_r, irq_en_r, irq_status_r, edge_r;
   logic [GPIO_WIDTH-1:0]    sync1_r, raw_in_r, raw_tick_r, data_in_r, data_in_prev_r;
   logic [DEBOUNCE_BITS-1:0] db_div_r, presc_r;
   logic                     ack_r, irq_r;
   logic [31:0]              dat_r;

   logic                     access_s, write_s, tick_s, db_wr_s, unused_s;
   logic [31:0]              wmask_s, rdata_s;
   logic [GPIO_WIDTH-1:0]    wmask_g_s, wdat_g_s, stable_s, edge_evt_s, w1c_s;
   logic [DEBOUNCE_BITS-1:0] wmask_d_s;

   assign access_s   = wb_cyc_i & wb_stb_i & ~ack_r;
   assign write_s    = access_s & wb_we_i;
   assign wmask_s    = byte_mask(wb_sel_i);
   assign wmask_g_s  = wmask_s[GPIO_WIDTH-1:0];
   assign wmask_d_s  = wmask_s[DEBOUNCE_BITS-1:0];
   assign wdat_g_s   = wb_dat_i[GPIO_WIDTH-1:0];
   assign db_wr_s    = write_s & (wb_adr_i == ADR_DB_DIV);
   assign tick_s     = (presc_r == db_div_r);
   // A pin is stable when its synchronised level matches the sample from the previous tick.
   assign stable_s   = ~(raw_in_r ^ raw_tick_r);
   assign edge_evt_s = (edge_r & data_in_r & ~data_in_prev_r) |
                       (~edge_r & ~data_in_r & data_in_prev_r);
   assign w1c_s      = (write_s && (wb_adr_i == ADR_IRQ_STATUS)) ? (wdat_g_s & wmask_g_s) : G_ZERO;
   assign unused_s   = ^{wb_dat_i, wmask_s};

   // Register read multiplexer, captured into dat_r on the acking edge.
   always_comb begin
      rdata_s = 32'd0;
      case (wb_adr_i)
         ADR_DATA_OUT:   rdata_s = 32'(data_out_r);
         ADR_DIR:        rdata_s = 32'(dir_r);
         ADR_DATA_IN:    rdata_s = 32'(data_in_r);
         ADR_IRQ_EN:     rdata_s = 32'(irq_en_r);
         ADR_IRQ_STATUS: rdata_s = 32'(irq_status_r);
         ADR_EDGE:       rdata_s = 32'(edge_r);
         ADR_DB_DIV:     rdata_s = 32'(db_div_r);
         ADR_RAW_IN:     rdata_s = 32'(raw_in_r);
         default:        rdata_s = 32'd0;
      endcase
   end

   // Bus handshake, control registers, interrupt status and registered IRQ line.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_r        <= 1'b0;
         dat_r        <= 32'd0;
         data_out_r   <= OUT_RESET;
         dir_r        <= G_ZERO;
         irq_en_r     <= G_ZERO;
         irq_status_r <= G_ZERO;
         edge_r       <= G_ZERO;
         db_div_r     <= D_ZERO;
         irq_r        <= 1'b0;
      end else begin
         ack_r <= access_s;
         if (access_s) begin
            dat_r <= rdata_s;
         end
         if (write_s) begin
            case (wb_adr_i)
               ADR_DATA_OUT: data_out_r <= merge_g(data_out_r, wdat_g_s, wmask_g_s);
               ADR_DIR:      dir_r      <= merge_g(dir_r, wdat_g_s, wmask_g_s);
               ADR_IRQ_EN:   irq_en_r   <= merge_g(irq_en_r, wdat_g_s, wmask_g_s);
               ADR_EDGE:     edge_r     <= merge_g(edge_r, wdat_g_s, wmask_g_s);
               ADR_DB_DIV:   db_div_r   <= (db_div_r & ~wmask_d_s) |
                                           (wb_dat_i[DEBOUNCE_BITS-1:0] & wmask_d_s);
               default:      ;
            endcase
         end
         // New edges are OR'd in after the clear so a coincident event survives.
         irq_status_r <= (irq_status_r & ~w1c_s) | edge_evt_s;
         irq_r        <= |(irq_status_r & irq_en_r);
      end
   end

   // Pad synchroniser, debounce prescaler and debounced input history.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sync1_r        <= G_ZERO;
         raw_in_r       <= G_ZERO;
         raw_tick_r     <= G_ZERO;
         data_in_r      <= G_ZERO;
         data_in_prev_r <= G_ZERO;
         presc_r        <= D_ZERO;
      end else begin
         sync1_r        <= gpio_i;
         raw_in_r       <= sync1_r;
         data_in_prev_r <= data_in_r;
         if (db_wr_s || tick_s) begin
            presc_r <= D_ZERO;
         end else begin
            presc_r <= presc_r + PRESC_ONE;
         end
         if (tick_s) begin
            raw_tick_r <= raw_in_r;
            data_in_r  <= (raw_in_r & stable_s) | (data_in_r & ~stable_s);
         end
      end
   end

   assign wb_ack_o  = ack_r;
   assign wb_dat_o  = dat_r;
   assign gpio_o    = data_out_r;
   assign gpio_oe_o = dir_r;
   assign irq_o     = irq_r;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Self-checking bench for wb_gpio_irq: directed scenarios plus random bus/pad
// traffic, every cycle compared against a behavioural model of the GPIO bank.
module tb_wb_gpio_irq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  adr = 3'd0;
   logic [31:0] dat_i = 32'd0;
   logic [3:0]  sel = 4'd0;
   logic        we = 1'b0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic [31:0] dat_o;
   logic        ack;
   logic [7:0]  gpio_in = 8'd0;
   logic [7:0]  gpio_out;
   logic [7:0]  gpio_oe;
   logic        irq;

   always #5 clk = ~clk;

   wb_gpio_irq #(.GPIO_WIDTH(8), .DEBOUNCE_BITS(16), .OUT_RESET(8'h00)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
      .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack),
      .gpio_i(gpio_in), .gpio_o(gpio_out), .gpio_oe_o(gpio_oe), .irq_o(irq)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   bit [7:0]  m_out, m_dir, m_en, m_stat, m_edge;
   bit [15:0] m_div, m_since_tick;
   bit        m_ack, m_irq;
   bit [31:0] m_dat;
   bit [7:0]  pad_q[$];   // [0]=pad two edges ago (=RAW_IN), [1]=last edge
   bit [7:0]  din_q[$];   // [0]=DATA_IN one cycle ago, [1]=DATA_IN now
   bit [7:0]  tick_q[$];  // RAW_IN samples at the last two ticks

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_out = 8'h00; m_dir = 8'h00; m_en = 8'h00; m_stat = 8'h00; m_edge = 8'h00;
      m_div = 16'd0; m_since_tick = 16'd0; m_ack = 1'b0; m_irq = 1'b0; m_dat = 32'd0;
      pad_q = '{8'h00, 8'h00};
      din_q = '{8'h00, 8'h00};
      tick_q = '{8'h00, 8'h00};
   endtask

   function automatic bit [31:0] model_read(input bit [2:0] a);
      case (a)
         3'd0:    return {24'd0, m_out};
         3'd1:    return {24'd0, m_dir};
         3'd2:    return {24'd0, din_q[1]};
         3'd3:    return {24'd0, m_en};
         3'd4:    return {24'd0, m_stat};
         3'd5:    return {24'd0, m_edge};
         3'd6:    return {16'd0, m_div};
         default: return {24'd0, pad_q[0]};
      endcase
   endfunction

   // One clock: predict the post-edge state from current inputs, then compare.
   task automatic step();
      bit        acc, wr, tick, irq_new;
      bit [7:0]  m8, d8, din_new, evt, stat_new, pad_now;
      bit [15:0] m16, cnt_new;
      bit [31:0] rv;
      acc = (cyc === 1'b1) && (stb === 1'b1) && !m_ack;
      wr  = acc && (we === 1'b1);
      m8  = {8{sel[0]}};
      m16 = {{8{sel[1]}}, {8{sel[0]}}};
      d8  = dat_i[7:0];
      rv  = model_read(adr);
      tick = (m_since_tick == m_div);
      din_new = din_q[1];
      if (tick) begin
         tick_q.push_back(pad_q[0]);
         void'(tick_q.pop_front());
         for (int b = 0; b < 8; b++)
            if (tick_q[0][b] == tick_q[1][b]) din_new[b] = tick_q[1][b];
      end
      for (int b = 0; b < 8; b++) begin
         if (m_edge[b]) evt[b] = din_q[1][b] && !din_q[0][b];
         else           evt[b] = !din_q[1][b] && din_q[0][b];
      end
      stat_new = m_stat;
      if (wr && adr == 3'd4) stat_new = stat_new & ~(d8 & m8);
      stat_new = stat_new | evt;
      irq_new  = (m_stat & m_en) != 8'h00;
      cnt_new  = (tick || (wr && adr == 3'd6)) ? 16'd0 : m_since_tick + 16'd1;
      pad_now  = gpio_in;
      @(posedge clk);
      #1;
      pad_q.push_back(pad_now); void'(pad_q.pop_front());
      din_q.push_back(din_new); void'(din_q.pop_front());
      if (wr) begin
         case (adr)
            3'd0: m_out  = (m_out & ~m8) | (d8 & m8);
            3'd1: m_dir  = (m_dir & ~m8) | (d8 & m8);
            3'd3: m_en   = (m_en & ~m8) | (d8 & m8);
            3'd5: m_edge = (m_edge & ~m8) | (d8 & m8);
            3'd6: m_div  = (m_div & ~m16) | (dat_i[15:0] & m16);
            default: ;
         endcase
      end
      if (acc) m_dat = rv;
      m_ack = acc;
      m_stat = stat_new;
      m_irq = irq_new;
      m_since_tick = cnt_new;
      chk("gpio_o", gpio_out, m_out);
      chk("gpio_oe", gpio_oe, m_dir);
      chk("irq_o", irq, m_irq);
      chk("ack", ack, m_ack);
      chk("dat_o", dat_o, m_dat);
   endtask

   task automatic wb_write(input bit [2:0] a, input bit [31:0] d, input bit [3:0] s);
      adr = a; dat_i = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      step();
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      step();
   endtask

   task automatic wb_read(input bit [2:0] a, output bit [31:0] d);
      adr = a; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      step();
      d = dat_o;
      cyc = 1'b0; stb = 1'b0;
      step();
   endtask

   task automatic hold_reset();
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      bit [31:0] rd;
      int op;
      bit [2:0] ra;
      bit [31:0] rdat;

      hold_reset();
      chk("rst_oe", gpio_oe, 32'h0);
      chk("rst_out", gpio_out, 32'h0);
      chk("rst_irq", irq, 32'h0);
      chk("rst_ack", ack, 32'h0);
      for (int a = 0; a < 7; a++) begin
         if (a != 2) begin
            wb_read(3'(a), rd);
            chk("rst_read", rd, 32'h0);
         end
      end

      // Output path and byte enables
      wb_write(3'd1, 32'h0000_00FF, 4'b0001);
      wb_write(3'd0, 32'hFFFF_FFA5, 4'b0001);
      chk("out_a5", gpio_out, 32'hA5);
      chk("oe_ff", gpio_oe, 32'hFF);
      wb_write(3'd0, 32'h0000_003C, 4'b0000);
      chk("sel0_nochange", gpio_out, 32'hA5);
      wb_read(3'd0, rd);
      chk("read_out_upper0", rd, 32'h0000_00A5);

      // Back-to-back: ack every second cycle
      adr = 3'd1; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      step(); chk("b2b_ack0", ack, 32'h1);
      step(); chk("b2b_ack1", ack, 32'h0);
      step(); chk("b2b_ack2", ack, 32'h1);
      cyc = 1'b0; stb = 1'b0;
      step();

      // DB_DIV=0: DATA_IN follows pad within 4 cycles
      gpio_in[3] = 1'b1;
      repeat (4) step();
      wb_read(3'd2, rd);
      chk("db0_pin3", rd[3], 32'h1);
      wb_write(3'd2, 32'h0000_0000, 4'hF);
      wb_read(3'd2, rd);
      chk("ro_ignored", rd[3], 32'h1);

      // DB_DIV=99: short glitch rejected, long level accepted
      wb_write(3'd6, 32'd99, 4'b0001);
      gpio_in[5] = 1'b1;
      repeat (30) step();
      gpio_in[5] = 1'b0;
      repeat (250) step();
      wb_read(3'd2, rd);
      chk("glitch_rejected", rd[5], 32'h0);
      gpio_in[6] = 1'b1;
      repeat (250) step();
      wb_read(3'd2, rd);
      chk("long_accepted", rd[6], 32'h1);
      wb_write(3'd6, 32'd0, 4'b0011);

      // Rising edge IRQ on pin 0 and W1C
      wb_write(3'd4, 32'hFF, 4'b0001);
      wb_write(3'd5, 32'h01, 4'b0001);
      wb_write(3'd3, 32'h01, 4'b0001);
      gpio_in[0] = 1'b1;
      repeat (8) step();
      wb_read(3'd4, rd);
      chk("rise_status", rd, 32'h01);
      chk("rise_irq", irq, 32'h1);
      wb_write(3'd4, 32'h01, 4'b0001);
      chk("w1c_irq", irq, 32'h0);

      // Falling mode on pin 2
      gpio_in[2] = 1'b1;
      repeat (8) step();
      wb_read(3'd4, rd);
      chk("fall_not_on_rise", rd[2], 32'h0);
      gpio_in[2] = 1'b0;
      repeat (8) step();
      wb_read(3'd4, rd);
      chk("fall_set", rd[2], 32'h1);

      // Edge landing on the same edge as its W1C: set wins
      wb_write(3'd5, 32'h03, 4'b0001);
      wb_write(3'd4, 32'hFF, 4'b0001);
      gpio_in[1] = 1'b1;
      repeat (4) step();
      wb_write(3'd4, 32'h02, 4'b0001);
      wb_read(3'd4, rd);
      chk("set_wins", rd[1], 32'h1);

      // Master drops stb before ack
      adr = 3'd0; dat_i = 32'h11; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      #2 stb = 1'b0; cyc = 1'b0; we = 1'b0;
      step();
      chk("stb_drop_noack", ack, 32'h0);
      chk("stb_drop_nowrite", gpio_out, 32'hA5);

      // Reset while ack high, then reset during a pending write
      adr = 3'd0; dat_i = 32'h77; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      step();
      #2 rst = 1'b1;
      #1;
      chk("rst_drops_ack", ack, 32'h0);
      chk("rst_out_reset", gpio_out, 32'h0);
      hold_reset();
      adr = 3'd0; dat_i = 32'h66; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("rst_pending_noack", ack, 32'h0);
      hold_reset();
      step();
      chk("rst_pending_discard", gpio_out, 32'h0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         op   = $urandom_range(0, 5);
         ra   = 3'($urandom_range(0, 7));
         rdat = $urandom();
         case (op)
            0, 1: begin
               if (ra == 3'd6) rdat = rdat & 32'h3;
               wb_write(ra, rdat, 4'($urandom_range(0, 15)));
            end
            2: wb_read(ra, rd);
            3: begin
               gpio_in = 8'($urandom());
               step();
            end
            4: begin
               adr = ra; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
               repeat (4) step();
               cyc = 1'b0; stb = 1'b0;
               step();
            end
            default: repeat ($urandom_range(1, 6)) step();
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
